// File: rtl/remote_comm_if.sv
// Host-side command/response bundle of the remote_comm UART link.
// The serial pins stay outside this bundle; it carries only the host handshake.
interface remote_comm_if;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (output cmd, snd_cmd, input cmd_snt, resp_rdy, resp);
  modport slave  (input cmd, snd_cmd, output cmd_snt, resp_rdy, resp);
endinterface

// File: rtl/remote_comm.sv
// Host-side UART link: sends a 16-bit command as two 8N1 bytes (high first)
// and captures single-byte responses from the robot.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,   // synchronous, active-high despite the name
  input  logic        RX,
  output logic        TX,
  remote_comm_if.slave host
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_TX_HI, S_TX_LO} snd_state_e;
  typedef enum logic       {R_IDLE, R_BUSY}          rcv_state_e;

  // ---------------- sender FSM ----------------
  snd_state_e snd_state, snd_next;
  logic [7:0] lo_hold;
  logic       tx_load, snd_accept, tx_done, cmd_snt_q;
  logic [7:0] tx_byte;

  // transmitter datapath
  logic [9:0]       tx_shift;
  logic [CNT_W-1:0] tx_baud;
  logic [3:0]       tx_bit;
  logic             tx_busy;

  assign tx_done = tx_busy && (tx_baud == BIT_END) && (tx_bit == 4'd9);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    snd_next   = snd_state;
    tx_load    = 1'b0;
    tx_byte    = lo_hold;
    snd_accept = 1'b0;
    case (snd_state)
      S_IDLE: if (host.snd_cmd) begin
        snd_accept = 1'b1;
        tx_load    = 1'b1;
        tx_byte    = host.cmd[15:8];
        snd_next   = S_TX_HI;
      end
      S_TX_HI: if (tx_done) begin
        tx_load  = 1'b1;
        snd_next = S_TX_LO;
      end
      S_TX_LO: if (tx_done) snd_next = S_IDLE;
      default: snd_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      snd_state <= S_IDLE;
      lo_hold   <= '0;
      cmd_snt_q <= 1'b0;
    end else begin
      snd_state <= snd_next;
      if (snd_accept) begin
        lo_hold   <= host.cmd[7:0];
        cmd_snt_q <= 1'b0;
      end else if (snd_state == S_TX_LO && tx_done) begin
        cmd_snt_q <= 1'b1;
      end
    end
  end

  // A load on the final stop-bit clock wins, so the low byte follows with no gap.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b0;
    end else if (tx_load) begin
      tx_shift <= {1'b1, tx_byte, 1'b0};
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_baud == BIT_END) begin
        tx_baud  <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        if (tx_bit == 4'd9) begin
          tx_bit  <= '0;
          tx_busy <= 1'b0;
        end else begin
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  assign TX = tx_shift[0];

  // ---------------- receiver FSM ----------------
  rcv_state_e       rcv_state, rcv_next;
  logic             rx_meta, rx_sync;
  logic [CNT_W-1:0] rx_baud;
  logic [3:0]       rx_bit;
  logic [7:0]       rx_shift, resp_q;
  logic             resp_rdy_q, rx_sample, rx_start, rx_done;

  // Start bit is checked half a bit in; later bits a full bit apart (mid-bit).
  assign rx_sample = (rcv_state == R_BUSY) &&
                     (rx_baud == ((rx_bit == 4'd0) ? HALF_END : BIT_END));

  always_comb begin
    rcv_next = rcv_state;
    rx_start = 1'b0;
    rx_done  = 1'b0;
    case (rcv_state)
      R_IDLE: if (!rx_sync) begin
        rx_start = 1'b1;
        rcv_next = R_BUSY;
      end
      R_BUSY: if (rx_sample) begin
        if (rx_bit == 4'd0 && rx_sync) begin
          rcv_next = R_IDLE;              // glitch, not a real start bit
        end else if (rx_bit == 4'd9) begin
          rx_done  = 1'b1;
          rcv_next = R_IDLE;
        end
      end
      default: rcv_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rcv_state  <= R_IDLE;
      rx_baud    <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      resp_q     <= '0;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_meta   <= RX;
      rx_sync   <= rx_meta;
      rcv_state <= rcv_next;
      if (rx_start) begin
        rx_baud <= '0;
        rx_bit  <= '0;
      end else if (rcv_state == R_BUSY) begin
        if (rx_sample) begin
          rx_baud <= '0;
          rx_bit  <= (rx_bit == 4'd9) ? 4'd0 : rx_bit + 4'd1;
          if (rx_bit >= 4'd1 && rx_bit <= 4'd8) rx_shift <= {rx_sync, rx_shift[7:1]};
        end else begin
          rx_baud <= rx_baud + 1'b1;
        end
      end
      if (rx_done) begin
        resp_q     <= rx_shift;
        resp_rdy_q <= 1'b1;
      end else if (rx_start || snd_accept) begin
        resp_rdy_q <= 1'b0;
      end
    end
  end

  assign host.cmd_snt  = cmd_snt_q;
  assign host.resp_rdy = resp_rdy_q;
  assign host.resp     = resp_q;

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: UART reference monitor on TX, UART driver
// on RX, byte scoreboards for both directions, a vector table plus corner cases.
module tb_remote_comm;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic RX = 1'b1;
  logic TX;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .host(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  rsp;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
  endtask

  always @(posedge clk) cyc++;

  // Reference UART receiver on TX; a reset seen on a rising edge aborts any frame.
  bit mon_abort = 1'b0;
  bit mon_busy = 1'b0;
  int mon_cnt = 0;
  int mon_bit = 0;
  logic [7:0] mon_byte = '0;
  logic [7:0] mon_exp;
  always @(posedge clk) if (rst_n) mon_abort = 1'b1;

  always @(negedge clk) begin
    if (mon_abort) begin
      mon_busy  = 1'b0;
      mon_abort = 1'b0;
    end else if (!mon_busy) begin
      if (TX === 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
        mon_bit  = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == ((mon_bit == 0) ? BD / 2 : BD)) begin
        mon_cnt = 0;
        if (mon_bit == 0) check("tx_start_bit", TX, 0);
        else if (mon_bit <= 8) mon_byte = {TX, mon_byte[7:1]};
        else begin
          check("tx_stop_bit", TX, 1);
          check("tx_byte_expected", tx_q.size() != 0, 1);
          if (tx_q.size() != 0) begin
            mon_exp = tx_q.pop_front();
            check("tx_byte", mon_byte, mon_exp);
          end
          mon_busy = 1'b0;
        end
        mon_bit++;
      end
    end
  end

  // Response scoreboard and edge counters.
  bit rdy_prev = 1'b0;
  bit snt_prev = 1'b0;
  int rdy_rises = 0;
  int snt_rises = 0;
  int rise_cyc = 0;
  int rx_fall_cyc = 0;
  logic [7:0] rsp_exp;
  always @(negedge clk) begin
    if (bus.resp_rdy && !rdy_prev) begin
      rdy_rises++;
      rise_cyc = cyc;
      check("resp_expected", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) begin
        rsp_exp = rx_q.pop_front();
        check("resp_byte", bus.resp, rsp_exp);
      end
    end
    if (bus.cmd_snt && !snt_prev) snt_rises++;
    rdy_prev = bus.resp_rdy;
    snt_prev = bus.cmd_snt;
  end

  task automatic send_cmd(input logic [15:0] c, input bit accepted);
    if (accepted) begin
      tx_q.push_back(c[15:8]);
      tx_q.push_back(c[7:0]);
    end
    @(negedge clk);
    bus.cmd = c;
    bus.snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    bus.snd_cmd = 1'b0;
    bus.cmd = '0;
  endtask

  // Counts rising edges after the snd_cmd edge until cmd_snt is seen high.
  task automatic wait_snt(input int budget, output int cycles);
    cycles = 0;
    while (!bus.cmd_snt && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Must be called on a falling edge; returns on a falling edge after the stop bit.
  task automatic send_rx(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      if (i == 0) rx_fall_cyc = cyc;
      repeat (BD) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[5];
  vec_t v;
  int c;
  int lat;
  int base;
  int zeros;

  initial begin
    vecs[0] = '{16'h4022, 8'hA5};
    vecs[1] = '{16'h1234, 8'h5A};
    vecs[2] = '{16'hFF00, 8'h00};
    vecs[3] = '{16'h00FF, 8'hFF};
    vecs[4] = '{16'hA55A, 8'h81};
    bus.cmd = '0;
    bus.snd_cmd = 1'b0;

    // Reset held for two clocks.
    repeat (2) @(posedge clk);
    #1;
    check("reset_tx", TX, 1);
    check("reset_cmd_snt", bus.cmd_snt, 0);
    check("reset_resp_rdy", bus.resp_rdy, 0);
    check("reset_resp", bus.resp, 8'h00);
    @(negedge clk) rst_n = 1'b0;
    repeat (4) @(posedge clk);

    // First command: start bit one cycle after snd_cmd, cmd_snt at 20*BD edges
    // after the sampling edge (i.e. in the 20*BD+1-th cycle after snd_cmd).
    send_cmd(16'h4022, 1'b1);
    check("tx_start_latency", TX, 0);
    check("cmd_snt_low_in_flight", bus.cmd_snt, 0);
    wait_snt(25 * BD, c);
    check("cmd_snt_latency", c, 20 * BD);

    // Vector table: command and response frames overlap.
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      fork
        begin
          send_cmd(v.cmd, 1'b1);
          wait_snt(25 * BD, c);
          check("vec_cmd_snt_latency", c, 20 * BD);
        end
        begin
          @(negedge clk);
          send_rx(v.rsp);
        end
      join
      check("vec_resp_rdy", bus.resp_rdy, 1);
      check("vec_resp", bus.resp, v.rsp);
    end

    // Single response 0xA5: latency and hold.
    repeat (3) @(negedge clk);
    send_rx(8'hA5);
    check("resp_rdy_after_a5", bus.resp_rdy, 1);
    check("resp_a5", bus.resp, 8'hA5);
    lat = rise_cyc - rx_fall_cyc;
    check("resp_rdy_latency_in_range", (lat >= 2 + BD / 2 + 9 * BD - 1) && (lat <= 2 + BD / 2 + 9 * BD + 1), 1);
    repeat (3 * BD) @(posedge clk);
    #1;
    check("resp_rdy_hold", bus.resp_rdy, 1);

    // Command 0x0000 with a 0xFFFF request mid-frame that must be ignored.
    base = snt_rises;
    send_cmd(16'h0000, 1'b1);
    check("resp_rdy_clr_on_cmd", bus.resp_rdy, 0);
    repeat (5 * BD) @(posedge clk);
    send_cmd(16'hFFFF, 1'b0);
    check("cmd_snt_low_after_ignored", bus.cmd_snt, 0);
    wait_snt(25 * BD, c);
    check("cmd_snt_after_ignored", bus.cmd_snt, 1);
    repeat (12 * BD) @(posedge clk);
    #1;
    check("cmd_snt_single_rise", snt_rises - base, 1);
    check("tx_idle_after_ignored", TX, 1);

    // Back-to-back responses.
    base = rdy_rises;
    @(negedge clk);
    send_rx(8'hA5);
    send_rx(8'h5A);
    check("resp_rdy_two_rises", rdy_rises - base, 2);
    check("resp_5a", bus.resp, 8'h5A);
    check("resp_rdy_after_5a", bus.resp_rdy, 1);

    // Reset during the high byte aborts the command.
    send_cmd(16'h4022, 1'b0);
    repeat (4 * BD) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx_high", TX, 1);
    check("abort_cmd_snt", bus.cmd_snt, 0);
    check("abort_resp_rdy", bus.resp_rdy, 0);
    check("abort_resp", bus.resp, 8'h00);
    @(negedge clk) rst_n = 1'b0;
    zeros = 0;
    repeat (25 * BD) begin
      @(posedge clk);
      #1;
      if (!TX) zeros++;
    end
    check("abort_no_low_byte", zeros, 0);
    check("abort_cmd_snt_stays_low", bus.cmd_snt, 0);
    send_cmd(16'h4022, 1'b1);
    wait_snt(25 * BD, c);
    check("post_reset_cmd_snt_latency", c, 20 * BD);

    repeat (2 * BD) @(posedge clk);
    check("tx_scoreboard_drained", tx_q.size(), 0);
    check("rx_scoreboard_drained", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
